// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch_unit
// Brief   : PC owner and instruction-port driver with in-flight tag tracking
//           and an output FIFO; optional IF_MISALIGN_CHK_EN adds fetch_fault.
// Revision: 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MEM_LAT    = 2,
  parameter int          ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic              fetch_fault
`endif
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = $clog2(FIFO_DEPTH + MEM_LAT + 1);

  logic [31:0]        r_fetch_pc;
  logic [MEM_LAT-1:0] r_tag_vld;
  logic [31:0]        r_tag_pc    [MEM_LAT];
  logic [31:0]        r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]        r_fifo_inst [FIFO_DEPTH];
  logic [c_PW-1:0]    r_wr_ptr;
  logic [c_PW-1:0]    r_rd_ptr;
  logic [c_CW-1:0]    r_count;
  logic [31:0]        r_last_pc;
  logic [31:0]        r_last_inst;

  logic [31:0]        w_target;
  logic [31:0]        w_issue_pc;
  logic [c_CW-1:0]    w_inflight;
  logic [c_CW-1:0]    w_occ;
  logic               w_misalign;
  logic               w_halt;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;

  assign w_target = redirect_pc & ~32'h3;

`ifdef IF_MISALIGN_CHK_EN
  logic r_fault;

  assign w_misalign  = |redirect_pc[1:0];
  assign w_halt      = r_fault;
  assign fetch_fault = r_fault;

  // The fault doubles as the halt flag: only an aligned redirect clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_fault <= 1'b0;
    else if (redirect_valid) r_fault <= w_misalign;
  end
`else
  assign w_misalign = 1'b0;
  assign w_halt     = 1'b0;
`endif

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_LAT; i++)
      w_inflight = w_inflight + c_CW'(r_tag_vld[i]);
  end

  // Credit uses the pre-dequeue count, so a same-cycle pop frees nothing.
  assign w_occ      = r_count + w_inflight;
  assign w_issue_pc = redirect_valid ? w_target : r_fetch_pc;
  assign w_issue    = redirect_valid ? !w_misalign
                                     : (!w_halt && (w_occ < c_CW'(FIFO_DEPTH)));
  assign imem_addr  = w_issue_pc[ADDR_W+1:2];

  assign if_valid = (r_count != '0);
  assign w_pop    = if_valid & if_ready;
  assign w_push   = r_tag_vld[MEM_LAT-1] & ~redirect_valid;
  assign if_pc    = if_valid ? r_fifo_pc[r_rd_ptr]   : r_last_pc;
  assign if_inst  = if_valid ? r_fifo_inst[r_rd_ptr] : r_last_inst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc  <= RESET_PC;
      r_tag_vld   <= '0;
      for (int i = 0; i < MEM_LAT; i++) r_tag_pc[i] <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_pc   <= '0;
      r_last_inst <= '0;
    end else begin
      r_tag_vld[0] <= w_issue;
      r_tag_pc[0]  <= w_issue_pc;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1] & ~redirect_valid;
        r_tag_pc[i]  <= r_tag_pc[i-1];
      end
      if (w_issue) r_fetch_pc <= w_issue_pc + 32'd4;
      if (if_valid) begin
        r_last_pc   <= if_pc;
        r_last_inst <= if_inst;
      end
      r_rd_ptr <= r_rd_ptr + c_PW'(w_pop);
      if (redirect_valid) begin
        r_wr_ptr <= r_rd_ptr + c_PW'(w_pop);
        r_count  <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + c_PW'(w_push);
        r_count  <= r_count + c_CW'(w_push) - c_CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_tag_pc[MEM_LAT-1];
      r_fifo_inst[r_wr_ptr] <= imem_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_fetch_unit
// Brief   : Scoreboard bench for inst_fetch_unit (IF_MISALIGN_CHK_EN optional)
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [13:0] imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef IF_MISALIGN_CHK_EN
  logic        fetch_fault;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] q [$];

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .RESET_PC(32'h0), .FIFO_DEPTH(4), .MEM_LAT(2), .ADDR_W(14)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst)
`ifdef IF_MISALIGN_CHK_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  // Two-cycle memory where word i holds the value i.
  logic [13:0] mem_a1;
  logic [31:0] mem_d2;
  always @(posedge clk) begin
    mem_a1 <= imem_addr;
    mem_d2 <= {18'b0, mem_a1};
  end
  assign imem_data = mem_d2;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {18'b0, pc[15:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load_stream(input logic [31:0] base);
    q.delete();
    for (int k = 0; k < 64; k++)
      q.push_back({base + 32'(4*k), word_of(base + 32'(4*k))});
  endtask

  task automatic wait_valid(input string tag, input int start, input int exp);
    int n = start;
    forever begin
      @(negedge clk);
      if (if_valid || n >= 20) break;
      n++;
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  always @(negedge clk) begin
    if (rst_n && if_valid && if_ready) begin
      if (q.size() == 0) begin
        check("sb_nonempty", 32'(q.size()), 32'd1);
      end else begin
        logic [63:0] e;
        e = q.pop_front();
        check("sb_pc", if_pc, e[63:32]);
        check("sb_inst", if_inst, e[31:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_inst", if_inst, 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);

    // Reset release: first word three cycles later, then one per cycle.
    @(posedge clk); #1 rst_n = 1'b1;
    load_stream(32'h0);
    wait_valid("lat_reset", 0, 3);
    check("first_pc", if_pc, 32'h0);
    repeat (16) begin @(negedge clk); check("tput", 32'(if_valid), 32'd1); end

    // Backpressure: head stable, fetch PC frozen four words past the head.
    @(posedge clk); #1 if_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", 32'(if_valid), 32'd1);
      check("bp_head", if_pc, q[0][63:32]);
    end
    check("bp_fetch_pc", 32'(imem_addr), word_of(q[0][63:32] + 32'd16));
    @(posedge clk); #1 if_ready = 1'b1;
    repeat (8) begin @(negedge clk); check("bp_resume", 32'(if_valid), 32'd1); end

    // Redirect while the FIFO is full.
    @(posedge clk); #1 if_ready = 1'b0;
    repeat (8) @(posedge clk);
    #1 if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1 redirect_valid = 1'b0; load_stream(32'h100);
    wait_valid("lat_redir", 1, 3);
    check("redir_pc", if_pc, 32'h100);
    check("redir_inst", if_inst, 32'h40);
    repeat (5) @(negedge clk);

    // Back-to-back redirects: only the second stream survives.
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(posedge clk); #1 redirect_pc = 32'h80; q.delete();
    @(posedge clk); #1 redirect_valid = 1'b0; load_stream(32'h80);
    wait_valid("lat_b2b", 1, 3);
    check("b2b_pc", if_pc, 32'h80);
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-stream.
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(if_valid), 32'd0);
    check("arst_pc", if_pc, 32'd0);
    check("arst_addr", 32'(imem_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; load_stream(32'h0);
    wait_valid("lat_rst2", 0, 3);
    check("rst2_pc", if_pc, 32'h0);
    repeat (6) @(negedge clk);

`ifdef IF_MISALIGN_CHK_EN
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(posedge clk); #1 redirect_valid = 1'b0; q.delete();
    check("fault_set", 32'(fetch_fault), 32'd1);
    repeat (6) @(negedge clk);
    check("fault_novalid", 32'(if_valid), 32'd0);
    check("fault_hold", 32'(fetch_fault), 32'd1);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1 redirect_valid = 1'b0; load_stream(32'h200);
    check("fault_clr", 32'(fetch_fault), 32'd0);
    wait_valid("lat_fault", 1, 3);
    check("fault_pc", if_pc, 32'h200);
`else
    // Low address bits are ignored: 0x106 fetches from 0x104.
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h106;
    @(posedge clk); #1 redirect_valid = 1'b0; load_stream(32'h104);
    wait_valid("lat_align", 1, 3);
    check("align_pc", if_pc, 32'h104);
`endif
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
